// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: funct3 encodings and FSM state type.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory-access stage (master) and data memory (slave).
interface mem_stage_if;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    input  dmem_rdata, dmem_ready
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
    output dmem_rdata, dmem_ready
  );

endinterface

// File: rtl/lsu_align.sv
// Combinational lane logic: store replication and byte enables, load extraction
// and extension, misalignment and illegal-funct3 detection.
module lsu_align
  import mem_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [31:0] storeData,
  input  logic [31:0] readWord,
  input  logic [2:0]  funct3,
  input  logic        isStore,
  output logic [31:0] wdata,
  output logic [3:0]  byteEn,
  output logic [31:0] loadData,
  output logic        misaligned,
  output logic        illegal
);

  logic [31:0] lane;

  assign lane = readWord >> {offset, 3'b000};

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    wdata      = storeData;
    byteEn     = 4'b0000;
    loadData   = lane;
    misaligned = 1'b0;
    illegal    = 1'b0;

    // Size lives in funct3[1:0] for both loads and stores.
    case (funct3[1:0])
      2'b00: begin
        wdata  = {4{storeData[7:0]}};
        byteEn = 4'b0001 << offset;
      end
      2'b01: begin
        wdata      = {2{storeData[15:0]}};
        byteEn     = 4'b0011 << {offset[1], 1'b0};
        misaligned = offset[0];
      end
      2'b10: begin
        byteEn     = 4'b1111;
        misaligned = |offset;
      end
      default: ;
    endcase

    case (funct3)
      F3_B:    loadData = {{24{lane[7]}}, lane[7:0]};
      F3_H:    loadData = {{16{lane[15]}}, lane[15:0]};
      F3_BU:   loadData = {24'd0, lane[7:0]};
      F3_HU:   loadData = {16'd0, lane[15:0]};
      default: loadData = lane;
    endcase

    if (isStore)
      illegal = funct3[2] | (&funct3[1:0]);
    else
      illegal = (&funct3[1:0]) | (funct3[2] & funct3[1]);
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: turns M-stage loads/stores into variable-latency bus
// transactions, stalls the pipeline while one is outstanding, and registers the load result.
module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        FaultM,
  mem_stage_if.master dmem
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT - 1);

  mem_state_t       state;
  logic [CNT_W-1:0] count;
  logic             dmemReq;
  logic             timeoutFault;

  logic        access;
  logic        isStore;
  logic        isLoad;
  logic        misaligned;
  logic        illegal;
  logic        accessFault;
  logic [31:0] loadData;

  // A store wins when both strobes are set.
  assign access  = MemReadM | MemWriteM;
  assign isStore = MemWriteM;
  assign isLoad  = MemReadM & ~MemWriteM;

  lsu_align u_align (
    .offset     (ALUResultM[1:0]),
    .storeData  (WriteDataM),
    .readWord   (dmem.dmem_rdata),
    .funct3     (Funct3M),
    .isStore    (isStore),
    .wdata      (dmem.dmem_wdata),
    .byteEn     (dmem.dmem_be),
    .loadData   (loadData),
    .misaligned (misaligned),
    .illegal    (illegal)
  );

  assign accessFault = misaligned | illegal;

  assign dmem.dmem_req  = dmemReq;
  assign dmem.dmem_we   = isStore;
  assign dmem.dmem_addr = {ALUResultM[31:2], 2'b00};

  // Stall starts combinationally in IDLE so upstream holds the instruction from its first cycle.
  assign StallM = (state == BUSY) || (state == IDLE && access && !accessFault);
  assign FaultM = (state == IDLE && access && accessFault) || timeoutFault;

  // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      count        <= '0;
      dmemReq      <= 1'b0;
      timeoutFault <= 1'b0;
      ReadDataM    <= '0;
    end else begin
      timeoutFault <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            if (accessFault) begin
              ReadDataM <= '0;
            end else begin
              state   <= BUSY;
              dmemReq <= 1'b1;
              count   <= '0;
            end
          end
        end
        BUSY: begin
          // A response on the final waiting cycle still completes the access.
          if (dmem.dmem_ready) begin
            dmemReq <= 1'b0;
            state   <= DONE;
            if (isLoad) ReadDataM <= loadData;
          end else if (count == LAST_COUNT) begin
            dmemReq      <= 1'b0;
            state        <= DONE;
            ReadDataM    <= '0;
            timeoutFault <= 1'b1;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed corner cases plus randomized
// accesses compared against an arithmetic reference model.
module tb_mem_stage;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] ALUResultM = '0;
  logic [31:0] WriteDataM = '0;
  logic        MemReadM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [2:0]  Funct3M = '0;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        FaultM;

  mem_stage_if dmemBus ();

  mem_stage #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .reset      (reset),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .Funct3M    (Funct3M),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .FaultM     (FaultM),
    .dmem       (dmemBus)
  );

  always #5 clk = ~clk;

  int          testsRun = 0;
  int          failCount = 0;
  logic [31:0] expReadData = '0;

  typedef struct packed {
    logic        fault;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] ldata;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: size = 1 << funct3[1:0] bytes, aligned iff addr % size == 0.
  function automatic exp_t model(input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [31:0] rdata, input logic [2:0] f3,
                                 input logic isStore);
    exp_t        r;
    int          off;
    int          nBytes;
    bit          legal;
    logic [31:0] mask;
    logic [31:0] v;
    off    = int'(addr % 4);
    nBytes = 1 << (f3 % 4);
    legal  = isStore ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    r.fault = !legal || (off % nBytes != 0);
    r.be    = 4'(((1 << nBytes) - 1) << off);
    mask    = (nBytes >= 4) ? 32'hFFFF_FFFF : 32'((1 << (8 * nBytes)) - 1);
    if (nBytes == 1)      r.wdata = (wd & 32'hFF) * 32'h0101_0101;
    else if (nBytes == 2) r.wdata = (wd & 32'hFFFF) * 32'h0001_0001;
    else                  r.wdata = wd;
    v = (rdata >> (8 * off)) & mask;
    if (f3 < 3'd4 && nBytes < 4 && v[8 * nBytes - 1]) v = v | ~mask;
    r.ldata = v;
    return r;
  endfunction

  task automatic idleCycle(input string name);
    @(posedge clk); #1;
    MemReadM   = 1'b0;
    MemWriteM  = 1'b0;
    ALUResultM = $urandom;
    Funct3M    = 3'($urandom_range(0, 7));
    dmemBus.dmem_ready = 1'($urandom_range(0, 1));
    dmemBus.dmem_rdata = $urandom;
    @(negedge clk);
    check({name, ":stall"}, StallM, 1'b0);
    check({name, ":fault"}, FaultM, 1'b0);
    check({name, ":req"}, dmemBus.dmem_req, 1'b0);
    check({name, ":rdHold"}, ReadDataM, expReadData);
  endtask

  // k = cycles after dmem_req rises before dmem_ready is presented.
  task automatic doAccess(input string name, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [2:0] f3, input logic rd, input logic wr,
                          input int k, input logic [31:0] rdata);
    exp_t e;
    int   stalls;
    int   reqs;
    int   busyExp;
    bit   timedOut;
    bit   done;
    e = model(addr, wd, rdata, f3, wr);
    @(posedge clk); #1;
    ALUResultM = addr;
    WriteDataM = wd;
    Funct3M    = f3;
    MemReadM   = rd;
    MemWriteM  = wr;
    dmemBus.dmem_ready = 1'($urandom_range(0, 1));
    dmemBus.dmem_rdata = $urandom;
    @(negedge clk);
    check({name, ":idleFault"}, FaultM, e.fault);
    check({name, ":idleStall"}, StallM, !e.fault);
    check({name, ":idleReq"}, dmemBus.dmem_req, 1'b0);
    check({name, ":idleRd"}, ReadDataM, expReadData);
    if (e.fault) begin
      expReadData = '0;
      return;
    end
    check({name, ":addr"}, dmemBus.dmem_addr, addr & ~32'h3);
    check({name, ":we"}, dmemBus.dmem_we, wr);
    if (wr) begin
      check({name, ":be"}, dmemBus.dmem_be, e.be);
      check({name, ":wdata"}, dmemBus.dmem_wdata, e.wdata);
    end
    timedOut = (k >= TIMEOUT);
    busyExp  = timedOut ? TIMEOUT : k + 1;
    stalls   = 1;
    reqs     = 0;
    done     = 1'b0;
    for (int c = 0; c < TIMEOUT + 3 && !done; c++) begin
      @(posedge clk); #1;
      dmemBus.dmem_ready = (c == k) || ((c > k || c >= TIMEOUT) && ($urandom_range(0, 1) == 1));
      dmemBus.dmem_rdata = (c == k) ? rdata : $urandom;
      @(negedge clk);
      if (StallM) begin
        stalls++;
        if (dmemBus.dmem_req) reqs++;
      end else begin
        done = 1'b1;
      end
    end
    if (timedOut)  expReadData = '0;
    else if (!wr)  expReadData = e.ldata;
    check({name, ":finished"}, done, 1'b1);
    check({name, ":stallCycles"}, stalls, busyExp + 1);
    check({name, ":reqCycles"}, reqs, busyExp);
    check({name, ":doneFault"}, FaultM, timedOut);
    check({name, ":doneReq"}, dmemBus.dmem_req, 1'b0);
    check({name, ":doneRd"}, ReadDataM, expReadData);
  endtask

  task automatic resetMidAccess();
    @(posedge clk); #1;
    ALUResultM = 32'h200;
    Funct3M    = 3'b010;
    MemReadM   = 1'b1;
    MemWriteM  = 1'b0;
    dmemBus.dmem_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    reset    = 1'b1;
    MemReadM = 1'b0;
    dmemBus.dmem_ready = 1'b1;
    dmemBus.dmem_rdata = 32'hCAFE_F00D;
    expReadData = '0;
    @(negedge clk);
    check("rstMid:req", dmemBus.dmem_req, 1'b0);
    check("rstMid:stall", StallM, 1'b0);
    check("rstMid:rd", ReadDataM, 32'h0);
    @(posedge clk); #1;
    dmemBus.dmem_ready = 1'b0;
    @(negedge clk);
    check("rstMid:lateReq", dmemBus.dmem_req, 1'b0);
    check("rstMid:lateRd", ReadDataM, 32'h0);
  endtask

  initial begin
    dmemBus.dmem_ready = 1'b0;
    dmemBus.dmem_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset:stall", StallM, 1'b0);
    check("reset:fault", FaultM, 1'b0);
    check("reset:req", dmemBus.dmem_req, 1'b0);
    check("reset:rd", ReadDataM, 32'h0);
    @(posedge clk); #1 reset = 1'b1;

    doAccess("lw100",     32'h100, 32'h0,         3'b010, 1'b1, 1'b0, 0, 32'hDEAD_BEEF);
    doAccess("lb103",     32'h103, 32'h0,         3'b000, 1'b1, 1'b0, 1, 32'h80FF_7F01);
    doAccess("lbu103",    32'h103, 32'h0,         3'b100, 1'b1, 1'b0, 2, 32'h80FF_7F01);
    doAccess("sh102",     32'h102, 32'h1234_ABCD, 3'b001, 1'b0, 1'b1, 0, 32'h0);
    doAccess("lwMis",     32'h101, 32'h0,         3'b010, 1'b1, 1'b0, 0, 32'h0);
    doAccess("lhu102",    32'h102, 32'h0,         3'b101, 1'b1, 1'b0, 1, 32'h8001_7FFF);
    doAccess("timeout",   32'h104, 32'h0,         3'b010, 1'b1, 1'b0, 10, 32'h1);
    doAccess("readyLast", 32'h108, 32'h0,         3'b010, 1'b1, 1'b0, TIMEOUT - 1, 32'h1122_3344);
    doAccess("bothSet",   32'h10C, 32'h5566_7788, 3'b010, 1'b1, 1'b1, 1, 32'hFFFF_FFFF);
    doAccess("sIllegal",  32'h110, 32'h0,         3'b011, 1'b0, 1'b1, 0, 32'h0);
    idleCycle("idle");
    resetMidAccess();

    for (int i = 0; i < 150; i++) begin
      int sel;
      sel = $urandom_range(0, 3);
      if (sel == 0)
        idleCycle("rndIdle");
      else
        doAccess("rnd", $urandom, $urandom, 3'($urandom_range(0, 7)),
                 sel != 2, sel != 1, $urandom_range(0, 5), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
